pipeline_interlock: RTL and testbench

PIPELINE_INTERLOCK -- requirements
Module: pipeline_interlock

---
 rtl/pipeline_ctrl_pkg.sv | 20 ++
 rtl/pipeline_interlock_if.sv | 37 +++
 rtl/sat_counter.sv | 26 ++
 rtl/pipeline_interlock.sv | 136 +++++++++++++
 tb/tb_pipeline_interlock.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline interlock.
//   state_t              : FSM encoding, also driven out on the debug "state" port
//   MEM_WAIT_MAX_DEFAULT : default consecutive mem_busy budget before mem_timeout
//   WAIT_CNT_W           : width of the memory wait counter
//   PERF_CNT_W           : width of the optional performance counters
//                          (INTERLOCK_PERF_CNT_EN)
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    FLUSH      = 2'd3
  } state_t;

  localparam int unsigned MEM_WAIT_MAX_DEFAULT = 255;
  localparam int          WAIT_CNT_W           = 8;
  localparam int          PERF_CNT_W           = 32;

endpackage

// File: rtl/pipeline_interlock_if.sv
// Hazard-request / stage-control bundle between hazard detection and the
// interlock.
//   Requests (master -> slave) : stall_req, mem_busy, branch_taken
//   Controls (slave -> master) : PC_Write, IFID_Write, IDEX_Write, EXMEM_Write,
//                                IFID_Flush, IDEX_Bubble, MEMWB_Bubble
// Signalling: there is no valid/ready pair. Each request is a level that is
// sampled every clock and acts in the same cycle. Each control is a
// combinational level that is valid for the whole cycle and is consumed by
// the stage registers on the next rising edge. No request is latched for
// later.
interface pipeline_interlock_if;

  logic stall_req;
  logic mem_busy;
  logic branch_taken;

  logic PC_Write;
  logic IFID_Write;
  logic IDEX_Write;
  logic EXMEM_Write;
  logic IFID_Flush;
  logic IDEX_Bubble;
  logic MEMWB_Bubble;

  modport master (
    output stall_req, mem_busy, branch_taken,
    input  PC_Write, IFID_Write, IDEX_Write, EXMEM_Write,
    input  IFID_Flush, IDEX_Bubble, MEMWB_Bubble
  );

  modport slave (
    input  stall_req, mem_busy, branch_taken,
    output PC_Write, IFID_Write, IDEX_Write, EXMEM_Write,
    output IFID_Flush, IDEX_Bubble, MEMWB_Bubble
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter. It holds at all-ones. clr has priority over inc.
//   clk, rst_n : clock and asynchronous active-low reset (count -> 0)
//   inc        : add one this cycle unless already saturated
//   clr        : synchronous clear
//   count      : current value
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_interlock.sv
// Pipeline interlock: turns hazard requests into stage register enables and
// bubble/flush controls. Priority is mem_busy > branch_taken > stall_req.
// Controls are combinational, so a request acts in the cycle it appears.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : pipeline_interlock_if.slave (requests in, controls out)
//   state       : current FSM state (RUN=0, LOAD_STALL=1, MEM_WAIT=2, FLUSH=3)
//   mem_timeout : sticky; mem_busy was held for MEM_WAIT_MAX consecutive cycles
//   proto_err   : sticky; stall_req was honoured in two consecutive cycles
// Optional feature INTERLOCK_PERF_CNT_EN adds these saturating 32-bit outputs:
//   stall_cycles    : number of cycles spent in LOAD_STALL
//   flush_count     : number of cycles in which a branch flush was applied
//   mem_wait_cycles : number of cycles in which mem_busy froze the pipe
module pipeline_interlock
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = MEM_WAIT_MAX_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_interlock_if.slave   bus,
  output logic [1:0]            state,
  output logic                  mem_timeout,
  output logic                  proto_err
`ifdef INTERLOCK_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cycles,
  output logic [PERF_CNT_W-1:0] flush_count,
  output logic [PERF_CNT_W-1:0] mem_wait_cycles
`endif
);

  state_t                cur_state, next_state;
  logic                  mem_req, br_req, st_req;
  logic                  pc_w, ifid_w, idex_w, exmem_w;
  logic                  ifid_fl, idex_bb, memwb_bb;
  logic                  stall_act;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  timeout_hit;

  // Requests are masked by rst_n. While reset is held, the controls therefore
  // show the RUN idle values, and a stall or wait stops at once.
  assign mem_req = bus.mem_busy     & rst_n;
  assign br_req  = bus.branch_taken & rst_n;
  assign st_req  = bus.stall_req    & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= RUN;
    else        cur_state <= next_state;
  end

  always_comb begin
    next_state = RUN;
    pc_w       = 1'b1;
    ifid_w     = 1'b1;
    idex_w     = 1'b1;
    exmem_w    = 1'b1;
    ifid_fl    = 1'b0;
    idex_bb    = 1'b0;
    memwb_bb   = 1'b0;
    stall_act  = 1'b0;
    if (mem_req) begin
      // Freeze the whole front of the pipe and let WB drain a bubble.
      pc_w       = 1'b0;
      ifid_w     = 1'b0;
      idex_w     = 1'b0;
      exmem_w    = 1'b0;
      memwb_bb   = 1'b1;
      next_state = MEM_WAIT;
    end else if (br_req) begin
      ifid_fl    = 1'b1;
      idex_bb    = 1'b1;
      next_state = FLUSH;
    end else if (st_req && (cur_state != FLUSH)) begin
      // In FLUSH, ID holds a squashed instruction, so a load-use stall
      // request from it is stale and is ignored.
      pc_w       = 1'b0;
      ifid_w     = 1'b0;
      idex_bb    = 1'b1;
      stall_act  = 1'b1;
      next_state = LOAD_STALL;
    end
  end

  assign bus.PC_Write     = pc_w;
  assign bus.IFID_Write   = ifid_w;
  assign bus.IDEX_Write   = idex_w;
  assign bus.EXMEM_Write  = exmem_w;
  assign bus.IFID_Flush   = ifid_fl;
  assign bus.IDEX_Bubble  = idex_bb;
  assign bus.MEMWB_Bubble = memwb_bb;
  assign state            = cur_state;

  // wait_cnt holds the number of consecutive busy cycles before this one.
  // It clears on the first idle cycle.
  sat_counter #(.WIDTH(WAIT_CNT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mem_req),
    .clr   (~mem_req),
    .count (wait_cnt)
  );

  // Including the current cycle, the busy run is wait_cnt + 1. The flag sets
  // on the edge where that run reaches MEM_WAIT_MAX.
  assign timeout_hit = mem_req &&
    (({{(32-WAIT_CNT_W){1'b0}}, wait_cnt} + 32'd1) >= MEM_WAIT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_timeout <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      if (timeout_hit)                           mem_timeout <= 1'b1;
      if (stall_act && (cur_state == LOAD_STALL)) proto_err  <= 1'b1;
    end
  end

`ifdef INTERLOCK_PERF_CNT_EN
  logic flush_act;
  assign flush_act = br_req & ~mem_req;

  sat_counter #(.WIDTH(PERF_CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(cur_state == LOAD_STALL), .clr(1'b0),
    .count(stall_cycles)
  );
  sat_counter #(.WIDTH(PERF_CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(flush_act), .clr(1'b0),
    .count(flush_count)
  );
  sat_counter #(.WIDTH(PERF_CNT_W)) u_memw_cnt (
    .clk(clk), .rst_n(rst_n), .inc(mem_req), .clr(1'b0),
    .count(mem_wait_cycles)
  );
`endif

endmodule

// File: tb/tb_pipeline_interlock.sv
// Bench for pipeline_interlock. The driver issues one request vector per
// cycle. For each vector it pushes the expected outputs into exp_q, using a
// reference model based on what the interlock did in the previous cycle. A
// negedge monitor pops each entry and compares it with the DUT outputs.
module tb_pipeline_interlock;
  import pipeline_ctrl_pkg::*;

  localparam int MAX     = 255;
  localparam int A_NONE  = 0;
  localparam int A_STALL = 1;
  localparam int A_MEM   = 2;
  localparam int A_FLUSH = 3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] state;
  logic       mem_timeout;
  logic       proto_err;
`ifdef INTERLOCK_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count, mem_wait_cycles;
`endif

  pipeline_interlock_if bus();

  pipeline_interlock #(.MEM_WAIT_MAX(MAX)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .state       (state),
    .mem_timeout (mem_timeout),
    .proto_err   (proto_err)
`ifdef INTERLOCK_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count),
    .mem_wait_cycles (mem_wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // act_prev is what the interlock did in the previous cycle. That is also
  // the state the DUT must report now.
  int          act_prev;
  int          busy_run;
  bit          m_tmo, m_perr;
  int unsigned m_stall_cnt, m_flush_cnt, m_mem_cnt;

  logic [10:0] exp_q[$];
  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  int          mon_cyc  = 0;

  task automatic model_reset();
    act_prev    = A_NONE;
    busy_run    = 0;
    m_tmo       = 1'b0;
    m_perr      = 1'b0;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
    m_mem_cnt   = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input bit st, input bit mb, input bit br);
    int         a;
    logic [6:0] ctl;
    @(posedge clk);
    #1;
    rst_n            = 1'b1;
    bus.stall_req    = st;
    bus.mem_busy     = mb;
    bus.branch_taken = br;
    if (mb)                               a = A_MEM;
    else if (br)                          a = A_FLUSH;
    else if (st && (act_prev != A_FLUSH)) a = A_STALL;
    else                                  a = A_NONE;
    // {PC, IFID, IDEX, EXMEM writes, IFID_Flush, IDEX_Bubble, MEMWB_Bubble}
    case (a)
      A_STALL: ctl = 7'b0011_010;
      A_MEM:   ctl = 7'b0000_001;
      A_FLUSH: ctl = 7'b1111_110;
      default: ctl = 7'b1111_000;
    endcase
    exp_q.push_back({ctl, 2'(act_prev), m_tmo, m_perr});
    if (act_prev == A_STALL) m_stall_cnt++;
    if (a == A_FLUSH)        m_flush_cnt++;
    if (a == A_MEM)          m_mem_cnt++;
    busy_run = mb ? busy_run + 1 : 0;
    if (mb && (busy_run >= MAX))               m_tmo  = 1'b1;
    if ((a == A_STALL) && (act_prev == A_STALL)) m_perr = 1'b1;
    act_prev = a;
  endtask

  // Assert reset just after an edge, with arbitrary requests still present.
  // The DUT must show idle RUN outputs in that same cycle.
  task automatic reset_cycle(input bit st, input bit mb, input bit br);
    @(posedge clk);
    #1;
    rst_n            = 1'b0;
    bus.stall_req    = st;
    bus.mem_busy     = mb;
    bus.branch_taken = br;
    model_reset();
    exp_q.push_back({7'b1111_000, 2'd0, 1'b0, 1'b0});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic busy(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b1, 1'b0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [10:0] exp_v, got_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {bus.PC_Write, bus.IFID_Write, bus.IDEX_Write, bus.EXMEM_Write,
               bus.IFID_Flush, bus.IDEX_Bubble, bus.MEMWB_Bubble,
               state, mem_timeout, proto_err};
      chk_cnt++;
      if (got_v === exp_v) pass_cnt++;
      else $display("FAIL outputs cycle %0d: got %b required %b",
                    mon_cyc, got_v, exp_v);
      mon_cyc++;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: stimulus did not complete, %0d/%0d checks passed",
             pass_cnt, chk_cnt);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n            = 1'b1;
    bus.stall_req    = 1'b0;
    bus.mem_busy     = 1'b0;
    bus.branch_taken = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;

    // Reset with requests active: they must be masked.
    reset_cycle(1'b1, 1'b1, 1'b1);
    reset_cycle(1'b1, 1'b0, 1'b1);
    idle(3);

    // Single load-use stall, then a double stall that raises proto_err.
    drive_cycle(1'b1, 1'b0, 1'b0);
    idle(2);
    drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0);
    idle(2);
    reset_cycle(1'b0, 1'b0, 1'b0);
    idle(1);

    // Branch together with a stall, then a stale stall while in FLUSH.
    drive_cycle(1'b1, 1'b0, 1'b1);
    drive_cycle(1'b1, 1'b0, 1'b0);
    idle(1);

    // mem_busy beats branch; 254 busy cycles stay under the limit.
    drive_cycle(1'b1, 1'b1, 1'b1);
    busy(253);
    idle(2);
    // 255 busy cycles set mem_timeout. Leave MEM_WAIT with a branch.
    busy(255);
    drive_cycle(1'b1, 1'b0, 1'b1);
    idle(2);

    // Reset in the middle of MEM_WAIT, then confirm the wait count restarts.
    busy(10);
    reset_cycle(1'b0, 1'b1, 1'b0);
    busy(254);
    idle(1);

    // Randomised mix, including short busy bursts and occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0)
        reset_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
      else if ($urandom_range(0, 39) == 0)
        busy($urandom_range(2, 8));
      else
        drive_cycle($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 4) == 0);
    end

    @(posedge clk);
    #1;
    bus.stall_req    = 1'b0;
    bus.mem_busy     = 1'b0;
    bus.branch_taken = 1'b0;

    chk_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL scoreboard drain: got %0d pending required 0", exp_q.size());

`ifdef INTERLOCK_PERF_CNT_EN
    chk_cnt++;
    if (stall_cycles == m_stall_cnt) pass_cnt++;
    else $display("FAIL stall_cycles: got %0d required %0d", stall_cycles, m_stall_cnt);
    chk_cnt++;
    if (flush_count == m_flush_cnt) pass_cnt++;
    else $display("FAIL flush_count: got %0d required %0d", flush_count, m_flush_cnt);
    chk_cnt++;
    if (mem_wait_cycles == m_mem_cnt) pass_cnt++;
    else $display("FAIL mem_wait_cycles: got %0d required %0d", mem_wait_cycles, m_mem_cnt);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
